// File: rtl/framebuffer_scanout_if.sv
// Bus bundle for the framebuffer scanout block: BRAM read port plus the
// upscaled pixel stream.
//
// Handshake: a pixel transfers in every cycle where pix_valid and pix_ready
// are both high at the rising clock edge. While pix_valid is high and
// pix_ready is low, pix_data, pix_sof and pix_eol hold their values, and
// pix_valid does not drop until the pixel is taken. The BRAM port has no
// handshake: fb_data is valid READ_LATENCY cycles after fb_rd_en.
interface framebuffer_scanout_if #(
  parameter int ADDR_BITS   = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int COLOR_WIDTH = 12
);
  logic                   fb_rd_en;
  logic [ADDR_BITS-1:0]   fb_addr;
  logic [DATA_WIDTH-1:0]  fb_data;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [COLOR_WIDTH-1:0] pix_data;
  logic                   pix_sof;
  logic                   pix_eol;

  // Scanout side: drives reads and the pixel stream.
  modport master (
    output fb_rd_en, fb_addr,
    input  fb_data,
    output pix_valid, pix_data, pix_sof, pix_eol,
    input  pix_ready
  );

  // Memory/display side.
  modport slave (
    input  fb_rd_en, fb_addr,
    output fb_data,
    input  pix_valid, pix_data, pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: reads the source framebuffer in raster order (each
// source line twice) and emits a 2x upscaled pixel stream with SOF/EOL
// markers. BRAM latency is hidden by a small prefetch FIFO whose reads are
// credit-limited against in-flight requests so it can never overflow.
module framebuffer_scanout #(
  parameter int SRC_WIDTH    = 512,
  parameter int SRC_HEIGHT   = 384,
  parameter int ADDR_BITS    = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int COLOR_WIDTH  = 12,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic frame_done,
  output logic [1:0] dbg_state,
  framebuffer_scanout_if.master bus
);

  localparam int FXW = $clog2(SRC_WIDTH);
  localparam int FLW = $clog2(2 * SRC_HEIGHT);
  localparam int OXW = $clog2(2 * SRC_WIDTH);
  localparam int OYW = FLW;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

  localparam logic [FXW-1:0] FX_LAST = FXW'(SRC_WIDTH - 1);
  localparam logic [FLW-1:0] FL_LAST = FLW'(2 * SRC_HEIGHT - 1);
  localparam logic [OXW-1:0] OX_LAST = OXW'(2 * SRC_WIDTH - 1);
  localparam logic [OYW-1:0] OY_LAST = OYW'(2 * SRC_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic [FXW-1:0]          fx_q;
  logic [FLW-1:0]          fline_q;
  logic [OXW-1:0]          ox_q;
  logic [OYW-1:0]          oy_q;
  logic                    rep_q;
  logic [READ_LATENCY-1:0] inflight_q;
  logic [READ_LATENCY-1:0] inflight_d;
  logic [PW:0]             wr_ptr_q;
  logic [PW:0]             rd_ptr_q;
  logic [COLOR_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic [PW:0]   fifo_count;
  logic [CW-1:0] inflight_cnt;
  logic          credit_ok;
  logic          issue;
  logic          last_read;
  logic          ret_valid;
  logic          fifo_empty;
  logic          hs;
  logic          pop;
  logic          last_hs;
  logic          start_acc;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);
  assign ret_valid  = inflight_q[READ_LATENCY-1];
  assign credit_ok  = (inflight_cnt + CW'(fifo_count)) < CW'(FIFO_DEPTH);
  assign issue      = (state_q == S_FETCH) && credit_ok;
  assign last_read  = (fx_q == FX_LAST) && (fline_q == FL_LAST);
  assign hs         = !fifo_empty && bus.pix_ready;
  assign pop        = hs && rep_q;
  assign last_hs    = hs && (ox_q == OX_LAST) && (oy_q == OY_LAST);
  assign start_acc  = (state_q == S_IDLE) && start;

  // Count reads still travelling through the BRAM pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
    end
  end

  // Next value of the in-flight shift register: new read enters at bit 0.
  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  // Frame state machine and fetch-side raster counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fx_q    <= '0;
      fline_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            fx_q    <= '0;
            fline_q <= '0;
          end
        end
        S_FETCH: begin
          if (issue) begin
            if (fx_q == FX_LAST) begin
              fx_q    <= '0;
              fline_q <= (fline_q == FL_LAST) ? '0 : fline_q + FLW'(1);
            end else begin
              fx_q <= fx_q + FXW'(1);
            end
            if (last_read) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_hs) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read pipeline tracking and FIFO pointers; reset drops late BRAM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (ret_valid) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // FIFO storage; only the colour bits are kept.
  always_ff @(posedge clk) begin
    if (ret_valid) mem_q[wr_ptr_q[PW-1:0]] <= bus.fb_data[COLOR_WIDTH-1:0];
  end

  // Output raster position and horizontal repeat phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ox_q  <= '0;
      oy_q  <= '0;
      rep_q <= 1'b0;
    end else if (start_acc) begin
      ox_q  <= '0;
      oy_q  <= '0;
      rep_q <= 1'b0;
    end else if (hs) begin
      rep_q <= ~rep_q;
      if (ox_q == OX_LAST) begin
        ox_q <= '0;
        oy_q <= (oy_q == OY_LAST) ? '0 : oy_q + OYW'(1);
      end else begin
        ox_q <= ox_q + OXW'(1);
      end
    end
  end

  assign bus.fb_rd_en  = issue;
  assign bus.fb_addr   = ADDR_BITS'(SRC_WIDTH) * ADDR_BITS'(fline_q >> 1) + ADDR_BITS'(fx_q);
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign bus.pix_sof   = !fifo_empty && (ox_q == '0) && (oy_q == '0);
  assign bus.pix_eol   = !fifo_empty && (ox_q == OX_LAST);

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Testbench for framebuffer_scanout on a reduced 8x6 source image
// (16x12 output). BRAM word at each address equals the address.
module tb_framebuffer_scanout;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int AB    = 18;
  localparam int DW    = 16;
  localparam int CWD   = 12;
  localparam int RL    = 2;
  localparam int FD    = 4;
  localparam int TOTAL = 4 * W * H;
  localparam int NRD   = 2 * H * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic frame_done;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  framebuffer_scanout_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .COLOR_WIDTH(CWD)) bus_if ();

  framebuffer_scanout #(
    .SRC_WIDTH(W), .SRC_HEIGHT(H), .ADDR_BITS(AB), .DATA_WIDTH(DW),
    .COLOR_WIDTH(CWD), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .frame_done(frame_done), .dbg_state(dbg_state), .bus(bus_if)
  );

  // ---------------- BRAM model: word = address ----------------
  logic [AB-1:0] pipe_addr [RL];
  logic          pipe_v    [RL];

  always @(posedge clk) begin
    pipe_v[0]    <= bus_if.fb_rd_en;
    pipe_addr[0] <= bus_if.fb_addr;
    for (int i = 1; i < RL; i++) begin
      pipe_v[i]    <= pipe_v[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  assign bus_if.fb_data = pipe_v[RL-1] ? DW'(pipe_addr[RL-1]) : 16'hBEEF;

  // ---------------- scoreboard state ----------------
  logic [13:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt, rd_idx, sof_cnt, eol_cnt, done_cnt, gap_cnt, max_out;
  bit prev_stall;
  bit full_ready;
  logic [13:0] prev_word;
  logic [13:0] mon_word;
  logic [CWD-1:0] got_px [TOTAL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd_addr(input int k);
    return 32'(W * ((k / W) / 2) + (k % W));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_frame();
    for (int oy = 0; oy < 2 * H; oy++) begin
      for (int ox = 0; ox < 2 * W; ox++) begin
        logic [CWD-1:0] d;
        d = CWD'(W * (oy / 2) + ox / 2);
        exp_q.push_back({(ox == 0 && oy == 0), (ox == 2 * W - 1), d});
      end
    end
  endtask

  task automatic clear_stats();
    hs_cnt = 0; rd_idx = 0; sof_cnt = 0; eol_cnt = 0;
    done_cnt = 0; gap_cnt = 0; max_out = 0; prev_stall = 0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1;
    end
    check("frame_done_seen", 32'(got), 1);
  endtask

  task automatic frame_checks(input bit no_gaps);
    #1;
    check("handshakes", hs_cnt, TOTAL);
    check("reads", rd_idx, NRD);
    check("sof_count", sof_cnt, 1);
    check("eol_count", eol_cnt, 2 * H);
    check("done_count", done_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
    check("fifo_occ_le_depth", 32'(max_out <= FD), 1);
    if (no_gaps) check("gaps", gap_cnt, 0);
  endtask

  // Downstream ready: always high, or ~30% duty.
  initial begin
    bus_if.pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus_if.pix_ready = full_ready ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    mon_word = {bus_if.pix_sof, bus_if.pix_eol, bus_if.pix_data};
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (bus_if.fb_rd_en) begin
        check("fb_addr", 32'(bus_if.fb_addr), exp_rd_addr(rd_idx));
        rd_idx++;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bus_if.pix_valid), 1);
        check("stall_data", 32'(mon_word), 32'(prev_word));
      end
      if (full_ready && hs_cnt > 0 && hs_cnt < TOTAL && !bus_if.pix_valid) gap_cnt++;
      if (bus_if.pix_valid && bus_if.pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(mon_word), 32'h3fff);
        end else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          check("pixel", 32'(mon_word), 32'(e));
        end
        if (hs_cnt < TOTAL) got_px[hs_cnt] = bus_if.pix_data;
        hs_cnt++;
        if (bus_if.pix_sof) sof_cnt++;
        if (bus_if.pix_eol) eol_cnt++;
      end
      if (rd_idx - hs_cnt / 2 > max_out) max_out = rd_idx - hs_cnt / 2;
      prev_stall = bus_if.pix_valid && !bus_if.pix_ready;
      prev_word  = mon_word;
      if (frame_done) done_cnt++;
    end
  end

  // Watchdog: the run must always end.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    start = 1'b0;
    full_ready = 1'b1;
    clear_stats();
    rst = 1'b1;
    #2 rst = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_rd_en", 32'(bus_if.fb_rd_en), 0);
    check("rst_addr", 32'(bus_if.fb_addr), 0);
    check("rst_valid", 32'(bus_if.pix_valid), 0);
    check("rst_data", 32'(bus_if.pix_data), 0);
    check("rst_sof", 32'(bus_if.pix_sof), 0);
    check("rst_eol", 32'(bus_if.pix_eol), 0);
    check("rst_state", 32'(dbg_state), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Frame A: full rate, start latency, ignored start while busy.
    clear_stats();
    push_frame();
    start_frame();
    @(negedge clk);  // cycle 1
    check("c1_rd_en", 32'(bus_if.fb_rd_en), 1);
    check("c1_addr", 32'(bus_if.fb_addr), 0);
    check("c1_busy", 32'(busy), 1);
    check("c1_valid", 32'(bus_if.pix_valid), 0);
    @(negedge clk);  // cycle 2
    check("c2_valid", 32'(bus_if.pix_valid), 0);
    @(negedge clk);  // cycle 3
    check("c3_valid", 32'(bus_if.pix_valid), 0);
    @(negedge clk);  // cycle 4
    check("c4_valid", 32'(bus_if.pix_valid), 1);
    check("c4_sof", 32'(bus_if.pix_sof), 1);
    check("c4_data", 32'(bus_if.pix_data), 0);
    repeat (95) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;  // cycle 100
    check("c100_busy", 32'(busy), 1);
    @(posedge clk); #1 start = 1'b0;
    wait_done(2000);
    frame_checks(1);
    check("spot_5_3", 32'(got_px[3 * 2 * W + 5]), 10);
    check("spot_last", 32'(got_px[11 * 2 * W + 15]), 47);
    check("spot_4_0", 32'(got_px[4]), 2);
    check("spot_5_0", 32'(got_px[5]), 2);
    repeat (40) @(negedge clk);
    #1;
    check("no_second_frame_reads", rd_idx, NRD);
    check("idle_busy", 32'(busy), 0);
    check("idle_valid", 32'(bus_if.pix_valid), 0);

    // Frame B: random backpressure.
    full_ready = 1'b0;
    clear_stats();
    push_frame();
    start_frame();
    wait_done(6000);
    frame_checks(0);
    full_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-frame, then a clean restart.
    clear_stats();
    push_frame();
    start_frame();
    begin
      bit reached = 0;
      for (int i = 0; i < 2000 && !reached; i++) begin
        @(negedge clk);
        if (hs_cnt >= 100) reached = 1;
      end
      check("reached_px100", 32'(reached), 1);
    end
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_en", 32'(bus_if.fb_rd_en), 0);
    check("mid_rst_addr", 32'(bus_if.fb_addr), 0);
    check("mid_rst_valid", 32'(bus_if.pix_valid), 0);
    check("mid_rst_data", 32'(bus_if.pix_data), 0);
    check("mid_rst_markers", 32'({bus_if.pix_sof, bus_if.pix_eol, frame_done}), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_stats();
    push_frame();
    start_frame();
    wait_done(2000);
    frame_checks(1);

    // Back-to-back frames: restart in the cycle after frame_done.
    repeat (3) @(negedge clk);
    clear_stats();
    push_frame();
    start_frame();
    wait_done(2000);
    frame_checks(1);
    clear_stats();
    push_frame();
    start_frame();
    wait_done(2000);
    frame_checks(1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Reads the 512×384 pixel framebuffer BRAM in raster order and emits a 2× upscaled 1024×768 pixel stream over a valid/ready handshake, with start-of-frame and end-of-line markers. It is the read-side counterpart to the rasterizer's pixel write port. It feeds the display encoder / VGA output stage from a single clock domain, replacing direct pixel-clock address arithmetic. It hides BRAM read latency with a credit-tracked prefetch FIFO, so it sustains one output pixel per cycle under no backpressure.

## Interface

Parameters:
- SRC_WIDTH, 512: source framebuffer width in pixels.
- SRC_HEIGHT, 384: source framebuffer height in lines.
- ADDR_BITS, 18: framebuffer address width.
- DATA_WIDTH, 16: padded BRAM word width.
- COLOR_WIDTH, 12: emitted colour width; the low bits of the BRAM word.
- READ_LATENCY, 2: BRAM cycles from fb_rd_en to valid fb_data.
- FIFO_DEPTH, 4: prefetch FIFO entries; must be a power of two and at least 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to scan one frame; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last output pixel handshake.
- fb_rd_en  out  1  BRAM read strobe.
- fb_addr  out  ADDR_BITS  BRAM read address, SRC_WIDTH*sy + sx.
- fb_data  in  DATA_WIDTH  BRAM read data, valid READ_LATENCY cycles after fb_rd_en.
- pix_valid  out  1  pix_data and the markers are valid.
- pix_ready  in  1  downstream accepts the current pixel.
- pix_data  out  COLOR_WIDTH  pixel colour, fb_data[COLOR_WIDTH-1:0].
- pix_sof  out  1  current pixel is output (0,0).
- pix_eol  out  1  current pixel is output x = 2*SRC_WIDTH-1.

## Operation

State machine:
- IDLE: start=1 moves to FETCH and clears all counters.
- FETCH: issues reads. Moves to DRAIN in the cycle the last read (fx = SRC_WIDTH-1, fline = 2*SRC_HEIGHT-1) is issued.
- DRAIN: no reads are issued. Moves to DONE when the last output pixel handshakes.
- DONE: frame_done=1 for exactly one cycle, then returns to IDLE.

Fetch side:
- Counters: fx (0..SRC_WIDTH-1) and fline (0..2*SRC_HEIGHT-1).
- Read address: fb_addr = SRC_WIDTH*(fline>>1) + fx.
- Each source line is read twice, once per output line; there is no line buffer.
- A read is issued when in_flight + fifo_count < FIFO_DEPTH.
- in_flight is a READ_LATENCY-deep valid shift register.
- Returning data is written into the FIFO.
- fx wraps to 0 with fline+1.

Output side:
- pix_valid = FIFO not empty.
- rep toggles on each handshake (pix_valid & pix_ready). The FIFO pops when rep=1, so each source pixel is emitted twice.
- Output counters: ox (0..2*SRC_WIDTH-1) and oy (0..2*SRC_HEIGHT-1), advancing on each handshake.
- pix_sof = pix_valid & ox==0 & oy==0.
- pix_eol = pix_valid & ox==2*SRC_WIDTH-1.
- With pix_ready=0, pix_data and the markers hold stable.

Boundary rules:
- start while busy: ignored.
- start in the same cycle as DONE: ignored.
- FIFO full: no read is issued, since the credit check covers in-flight reads. The FIFO never overflows, and it is never read when empty.
- Simultaneous FIFO push and pop: fifo_count is unchanged.
- Reset is asynchronous and may occur mid-frame. It clears the state machine, all counters, in_flight, the FIFO pointers and rep. Any BRAM data still returning after reset is discarded.

## Timing

Reset values:
- All outputs are 0: busy, frame_done, fb_rd_en, fb_addr, pix_valid, pix_data, pix_sof, pix_eol.

Latency, with start sampled at cycle 0:
- Cycle 1: fb_rd_en=1, fb_addr=0.
- Cycle 1+READ_LATENCY: FIFO write.
- Cycle 2+READ_LATENCY: pix_valid=1 and pix_sof=1. This is cycle 4 at the default READ_LATENCY.

Throughput:
- With pix_ready held high, one pixel is emitted per cycle with no bubbles after the first pixel.
- A full frame takes 786432 handshakes.
- frame_done fires the cycle after the final handshake.

Backpressure:
- Reads stall within FIFO_DEPTH cycles of pix_ready going low.
- Output resumes in the cycle pix_ready returns high.

## Test plan

- Full frame, pix_ready=1, BRAM word at each address = its address:
  - 786432 pixels are emitted with no gaps after the first.
  - pix_sof occurs exactly once; pix_eol occurs 768 times.
  - frame_done occurs once.
- Pixel mapping spot checks, same memory image:
  - Output (ox=5, oy=3) carries data 514[11:0].
  - Output (1023, 767) carries (512*383+511)[11:0].
  - Outputs (4, 0) and (5, 0) carry the same value.
- Random backpressure, pix_ready 30% duty:
  - The output sequence is identical to the previous test.
  - Data holds stable while stalled.
  - FIFO occupancy never exceeds 4; no underflow or overflow assertions fire.
- Start latency: start at cycle 0 gives fb_rd_en at cycle 1 and first pix_valid with pix_sof at cycle 4. A start pulse at cycle 100 while busy is ignored and produces no second frame.
- Reset mid-frame: assert rst=0 at pixel 1000.
  - All outputs go to 0 immediately.
  - After release and a new start, the frame restarts at address 0 with pix_sof.
- Back-to-back frames: start is re-asserted in the cycle after frame_done, and the second frame is bit-identical to the first.
